// File: rtl/line_mem_pkg.sv
// Shared types and constants for the cache-line backing memory model.
package line_mem_pkg;

    localparam int LINE_W_DEF = 256;
    localparam int OFFSET_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

endpackage

// File: rtl/line_mem_array.sv
// Line storage: one synchronous write port, combinational read by the same index.
module line_mem_array #(
    parameter int LINE_W     = 256,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/line_memory_backend.sv
// Fixed-latency line memory behind the data cache: enable/write/ack handshake,
// one-cycle ack per request, abort when enable drops before completion.
//
// state  | meaning
// S_IDLE | no request in flight; enable_i high captures a new request
// S_WAIT | latency countdown; enable_i low aborts without side effects
// S_ACK  | request completed this cycle, ack_o pulses
module line_memory_backend
    import line_mem_pkg::*;
#(
    parameter int LINE_W     = LINE_W_DEF,
    parameter int DEPTH_LOG2 = 9,
    parameter int LATENCY    = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    cap_write;
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic [LINE_W-1:0]       cap_data;
    logic [LINE_W-1:0]       rd_line;
    logic                    accept;
    logic                    commit;
    logic                    unused_addr;

    // Offset bits and the aliased upper address bits take no part in decode.
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+OFFSET_W], addr_i[OFFSET_W-1:0]};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable_i) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable_i) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ack_o  = (state == S_ACK);
    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            data_o <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit && !cap_write) begin
                data_o <= rd_line;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cap_write <= 1'b0;
            cap_idx   <= '0;
        end else if (accept) begin
            cap_write <= write_i;
            cap_idx   <= addr_i[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];
        end
    end

    // Wide write-data capture carries no reset; it is only consumed after an accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            cap_data <= data_i;
        end
    end

    line_mem_array #(
        .LINE_W     (LINE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i (clk_i),
        .we    (commit && cap_write),
        .idx   (cap_idx),
        .wdata (cap_data),
        .rdata (rd_line)
    );

endmodule

// File: tb/tb_line_memory_backend.sv
// Directed bench for line_memory_backend: LATENCY=10 instance plus a LATENCY=1 instance.
module tb_line_memory_backend;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable, write, ack, busy;
    logic [31:0]  addr;
    logic [255:0] wdata, data_o;
    logic         enable1, write1, ack1, busy1;
    logic [31:0]  addr1;
    logic [255:0] wdata1, data_o1;

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] P_BEEF = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] P_L7   = {8{32'h7777_0007}};
    localparam logic [255:0] P_L3   = {8{32'h3333_0003}};
    localparam logic [255:0] P_80   = {8{32'hCAFE_0080}};
    localparam logic [255:0] P_ABT  = {8{32'h1234_5678}};
    localparam logic [255:0] P_L1   = {8{32'h1111_2222}};
    localparam logic [255:0] P_RST  = {8{32'h0BAD_F00D}};

    always #5 clk = ~clk;

    line_memory_backend #(.LINE_W(256), .DEPTH_LOG2(9), .LATENCY(10)) u_dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .enable_i (enable),
        .write_i  (write),
        .addr_i   (addr),
        .data_i   (wdata),
        .ack_o    (ack),
        .data_o   (data_o),
        .busy_o   (busy)
    );

    line_memory_backend #(.LINE_W(256), .DEPTH_LOG2(9), .LATENCY(1)) u_dut1 (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .enable_i (enable1),
        .write_i  (write1),
        .addr_i   (addr1),
        .data_i   (wdata1),
        .ack_o    (ack1),
        .data_o   (data_o1),
        .busy_o   (busy1)
    );

    // Issue one request, return edges from acceptance to ack (300 = timed out).
    task automatic do_req(input int sel, input logic w, input logic [31:0] a,
                          input logic [255:0] d, output int edges, output logic [255:0] q);
        logic seen;
        @(negedge clk);
        if (sel == 0) begin enable = 1'b1; write = w; addr = a; wdata = d; end
        else begin enable1 = 1'b1; write1 = w; addr1 = a; wdata1 = d; end
        @(posedge clk);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            seen = (sel == 0) ? ack : ack1;
        end
        q = (sel == 0) ? data_o : data_o1;
        @(negedge clk);
        if (sel == 0) enable = 1'b0; else enable1 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        enable1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: ack=%b busy=%b want 0 0", ack, busy);
        end
        checks++;
        if (data_o !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", data_o);
        end
        checks++;
        if (ack1 !== 1'b0 || busy1 !== 1'b0 || data_o1 !== '0) begin
            errors++; $display("FAIL reset_lat1: ack=%b busy=%b", ack1, busy1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        int e;
        logic [255:0] q;
        do_req(0, 1'b1, 32'h0000_0040, P_BEEF, e, q);
        checks++;
        if (e !== 10) begin errors++; $display("FAIL wr_latency: got %0d want 10", e); end
        checks++;
        if (q !== '0) begin errors++; $display("FAIL wr_data_o_kept: got %h want 0", q); end
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_ack_single: ack=%b busy=%b want 0 0", ack, busy);
        end
        do_req(0, 1'b0, 32'h0000_0040, '0, e, q);
        checks++;
        if (e !== 10) begin errors++; $display("FAIL rd_latency: got %0d want 10", e); end
        checks++;
        if (q !== P_BEEF) begin errors++; $display("FAIL rd_data: got %h want %h", q, P_BEEF); end
    endtask

    task automatic test_alias;
        int e;
        logic [255:0] q;
        do_req(0, 1'b0, 32'h0000_005C, '0, e, q);
        checks++;
        if (q !== P_BEEF || e !== 10) begin
            errors++; $display("FAIL alias_offset: got %h lat %0d want %h lat 10", q, e, P_BEEF);
        end
        do_req(0, 1'b0, 32'h0000_4040, '0, e, q);
        checks++;
        if (q !== P_BEEF || e !== 10) begin
            errors++; $display("FAIL alias_wrap: got %h lat %0d want %h lat 10", q, e, P_BEEF);
        end
    endtask

    task automatic test_back_to_back;
        int e, nack, t1, t2;
        logic [255:0] q, q1, q2;
        do_req(0, 1'b1, 32'h0000_00E0, P_L7, e, q);
        @(negedge clk);
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0060; wdata = P_L3;
        nack = 0; t1 = 0; t2 = 0; q1 = '0; q2 = '0;
        for (int c = 1; c <= 60 && nack < 2; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                nack++;
                if (nack == 1) begin t1 = c; q1 = data_o; end
                else begin t2 = c; q2 = data_o; end
            end
            @(negedge clk);
            if (ack && nack == 1) begin write = 1'b0; addr = 32'h0000_00E0; end
            if (nack == 2) enable = 1'b0;
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) nack++;
        end
        checks++;
        if (nack !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d want 2", nack); end
        // ack cycle, one IDLE cycle, LATENCY countdown, second ack
        checks++;
        if (t2 - t1 !== 12) begin errors++; $display("FAIL b2b_spacing: got %0d want 12", t2 - t1); end
        checks++;
        if (q1 !== P_BEEF) begin errors++; $display("FAIL b2b_write_keeps: got %h want %h", q1, P_BEEF); end
        checks++;
        if (q2 !== P_L7) begin errors++; $display("FAIL b2b_read_data: got %h want %h", q2, P_L7); end
        do_req(0, 1'b0, 32'h0000_0060, '0, e, q);
        checks++;
        if (q !== P_L3) begin errors++; $display("FAIL b2b_line3: got %h want %h", q, P_L3); end
    endtask

    task automatic test_abort;
        int e, nack;
        logic [255:0] q;
        do_req(0, 1'b1, 32'h0000_0080, P_80, e, q);
        @(negedge clk);
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0080; wdata = P_ABT;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        nack = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ack) nack++;
        end
        checks++;
        if (nack !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_ack: acks=%0d busy=%b want 0 0", nack, busy);
        end
        checks++;
        if (data_o !== P_L3) begin errors++; $display("FAIL abort_data_o: got %h want %h", data_o, P_L3); end
        do_req(0, 1'b0, 32'h0000_0080, '0, e, q);
        checks++;
        if (q !== P_80) begin errors++; $display("FAIL abort_no_write: got %h want %h", q, P_80); end
    endtask

    task automatic test_latency1;
        int e;
        logic [255:0] q;
        do_req(1, 1'b1, 32'h0000_0040, P_L1, e, q);
        checks++;
        if (e !== 1) begin errors++; $display("FAIL lat1_wr: got %0d want 1", e); end
        do_req(1, 1'b0, 32'h0000_0040, '0, e, q);
        checks++;
        if (e !== 1 || q !== P_L1) begin
            errors++; $display("FAIL lat1_rd: lat %0d data %h want 1 %h", e, q, P_L1);
        end
        @(posedge clk); #1;
        checks++;
        if (ack1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL lat1_ack_single: ack=%b busy=%b want 0 0", ack1, busy1);
        end
    endtask

    task automatic test_addr_change;
        int c, hit;
        logic [255:0] q;
        int e;
        @(negedge clk);
        enable = 1'b1; write = 1'b0; addr = 32'h0000_0040; wdata = '0;
        @(posedge clk);
        c = 0; hit = 0;
        while (hit == 0 && c < 300) begin
            @(posedge clk); #1;
            c++;
            if (ack) hit = 1;
            if (c == 5) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", busy); end
            end
            @(negedge clk);
            if (c == 3) begin write = 1'b1; addr = 32'h0000_0060; wdata = P_ABT; end
            if (hit == 1) enable = 1'b0;
        end
        checks++;
        if (c !== 10 || data_o !== P_BEEF) begin
            errors++; $display("FAIL addr_change: lat %0d data %h want 10 %h", c, data_o, P_BEEF);
        end
        do_req(0, 1'b0, 32'h0000_0060, '0, e, q);
        checks++;
        if (q !== P_L3) begin errors++; $display("FAIL addr_change_nowr: got %h want %h", q, P_L3); end
    endtask

    task automatic test_reset_mid_wait;
        int e, nack;
        logic [255:0] q;
        @(negedge clk);
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0040; wdata = P_RST;
        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1 || data_o !== P_L3) begin
            errors++; $display("FAIL pre_reset: busy=%b data %h want 1 %h", busy, data_o, P_L3);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0 || data_o !== '0) begin
            errors++; $display("FAIL async_reset: ack=%b busy=%b data %h want 0 0 0", ack, busy, data_o);
        end
        @(negedge clk);
        enable = 1'b0;
        rst_n = 1'b1;
        nack = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ack) nack++;
        end
        checks++;
        if (nack !== 0) begin errors++; $display("FAIL reset_no_ack: got %0d want 0", nack); end
        do_req(0, 1'b0, 32'h0000_0040, '0, e, q);
        checks++;
        if (q !== P_BEEF) begin errors++; $display("FAIL reset_write_lost: got %h want %h", q, P_BEEF); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_back_to_back();
        test_abort();
        test_latency1();
        test_addr_change();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
